// File: rtl/hf_compression.sv
// Huffman encoder: 4-bit symbols looked up in a 16-entry programmable code table, codeword serialised MSB-first.
// Optional HF_PREFETCH_EN: accept the next symbol during the last-bit cycle for gapless back-to-back codewords.
module hf_compression (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [3:0]  sym_in,
    input  logic        sym_in_valid,
    output logic        sym_in_ready,
    input  logic        tbl_wr_en,
    input  logic [3:0]  tbl_wr_sym,
    input  logic [15:0] tbl_wr_code,
    input  logic [4:0]  tbl_wr_len,
    output logic        hf_out,
    output logic        hf_out_valid,
    output logic        hf_out_last,
    output logic        hf_err
);

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LEN_W   = 5;
    localparam int unsigned NUM_SYM = 16;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [MAX_LEN-1:0] tbl_code [NUM_SYM];
    logic [LEN_W-1:0]   tbl_len  [NUM_SYM];

    logic [0:0]         state, state_n;
    logic [MAX_LEN-1:0] sh_code, sh_code_n;
    logic [LEN_W-1:0]   cnt, cnt_n;
    logic               out_n, valid_n, last_n, err_n;
    logic [MAX_LEN-1:0] rd_code;
    logic [LEN_W-1:0]   rd_len;
    logic               accept;

`ifdef HF_PREFETCH_EN
    // The last-bit cycle of a codeword doubles as an accept slot.
    assign sym_in_ready = ~Reset & ((state == S_IDLE) | ((state == S_SHIFT) & (cnt == LEN_W'(1))));
`else
    assign sym_in_ready = ~Reset & (state == S_IDLE);
`endif

    assign accept  = sym_in_valid & sym_in_ready;
    assign rd_code = tbl_code[sym_in];
    assign rd_len  = tbl_len[sym_in];

    // Next-state and next-output decode; an accept overrides the shift path.
    always_comb begin
        state_n   = state;
        sh_code_n = sh_code;
        cnt_n     = cnt;
        out_n     = 1'b0;
        valid_n   = 1'b0;
        last_n    = 1'b0;
        err_n     = 1'b0;

        case (state)
            S_IDLE: begin
                state_n = S_IDLE;
            end
            S_SHIFT: begin
                if (cnt > LEN_W'(1)) begin
                    cnt_n   = cnt - LEN_W'(1);
                    out_n   = sh_code[4'(cnt - LEN_W'(2))];
                    valid_n = 1'b1;
                    last_n  = (cnt == LEN_W'(2));
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (accept) begin
            if (rd_len != LEN_W'(0)) begin
                state_n   = S_SHIFT;
                sh_code_n = rd_code;
                cnt_n     = rd_len;
                out_n     = rd_code[4'(rd_len - LEN_W'(1))];
                valid_n   = 1'b1;
                last_n    = (rd_len == LEN_W'(1));
            end else begin
                err_n   = 1'b1;
                state_n = S_IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state        <= S_IDLE;
            sh_code      <= '0;
            cnt          <= '0;
            hf_out       <= 1'b0;
            hf_out_valid <= 1'b0;
            hf_out_last  <= 1'b0;
            hf_err       <= 1'b0;
        end else begin
            state        <= state_n;
            sh_code      <= sh_code_n;
            cnt          <= cnt_n;
            hf_out       <= out_n;
            hf_out_valid <= valid_n;
            hf_out_last  <= last_n;
            hf_err       <= err_n;
        end
    end

    // Code table; a same-cycle lookup sees the pre-write entry.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                tbl_code[i] <= '0;
                tbl_len[i]  <= '0;
            end
        end else if (tbl_wr_en) begin
            tbl_code[tbl_wr_sym] <= tbl_wr_code;
            tbl_len[tbl_wr_sym]  <= (tbl_wr_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : tbl_wr_len;
        end
    end

endmodule

// File: tb/tb_hf_compression.sv
// Randomised self-checking bench for hf_compression against a bit-queue reference model.
module tb_hf_compression;

`ifdef HF_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        Reset;
    logic [3:0]  sym_in;
    logic        sym_in_valid;
    logic        sym_in_ready;
    logic        tbl_wr_en;
    logic [3:0]  tbl_wr_sym;
    logic [15:0] tbl_wr_code;
    logic [4:0]  tbl_wr_len;
    logic        hf_out;
    logic        hf_out_valid;
    logic        hf_out_last;
    logic        hf_err;

    hf_compression dut (
        .CLK(CLK), .Reset(Reset),
        .sym_in(sym_in), .sym_in_valid(sym_in_valid), .sym_in_ready(sym_in_ready),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_sym(tbl_wr_sym), .tbl_wr_code(tbl_wr_code), .tbl_wr_len(tbl_wr_len),
        .hf_out(hf_out), .hf_out_valid(hf_out_valid), .hf_out_last(hf_out_last), .hf_err(hf_err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: table plus a queue of {bit,last} pairs still to be shown on hf_out.
    logic [15:0] m_code [16];
    int          m_len  [16];
    logic [1:0]  m_q    [$];
    logic        m_bit, m_valid, m_last, m_err;

    logic s_out, s_valid, s_last, s_err, s_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_code[i] = '0;
            m_len[i]  = 0;
        end
        m_q.delete();
        m_bit = 0; m_valid = 0; m_last = 0; m_err = 0;
    endtask

    task automatic idle_inputs();
        Reset = 0; sym_in_valid = 0; sym_in = '0;
        tbl_wr_en = 0; tbl_wr_sym = '0; tbl_wr_code = '0; tbl_wr_len = '0;
    endtask

    // One clock: check outputs mid-cycle, advance the model with this cycle's inputs.
    task automatic tick();
        logic exp_ready;
        int   len;
        exp_ready = !Reset && (m_q.size() == 0) && (!m_valid || (PF && m_last));
        @(negedge CLK);
        s_out = hf_out; s_valid = hf_out_valid; s_last = hf_out_last; s_err = hf_err; s_ready = sym_in_ready;
        check("ready", 32'(s_ready), 32'(exp_ready));
        check("valid", 32'(s_valid), 32'(m_valid));
        check("out",   32'(s_out),   32'(m_bit));
        check("last",  32'(s_last),  32'(m_last));
        check("err",   32'(s_err),   32'(m_err));
        if (Reset) begin
            model_clear();
        end else begin
            m_err = 0;
            if (sym_in_valid && exp_ready) begin
                len = m_len[sym_in];
                if (len == 0) m_err = 1;
                for (int i = len - 1; i >= 0; i--) m_q.push_back({m_code[sym_in][i], i == 0});
            end
            if (tbl_wr_en) begin
                m_code[tbl_wr_sym] = tbl_wr_code;
                m_len[tbl_wr_sym]  = (tbl_wr_len > 5'd16) ? 16 : int'(tbl_wr_len);
            end
            if (m_q.size() > 0) begin
                {m_bit, m_last} = m_q.pop_front();
                m_valid = 1;
            end else begin
                m_bit = 0; m_last = 0; m_valid = 0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic write_tbl(input logic [3:0] s, input logic [15:0] c, input logic [4:0] l);
        idle_inputs();
        tbl_wr_en = 1; tbl_wr_sym = s; tbl_wr_code = c; tbl_wr_len = l;
        tick();
        idle_inputs();
    endtask

    task automatic send(input logic [3:0] s);
        idle_inputs();
        sym_in_valid = 1; sym_in = s;
        tick();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1;
        tick();
        tick();
        idle_inputs();
    endtask

    initial begin
        int ones, lasts;
        model_clear();
        idle_inputs();
        Reset = 1;
        @(posedge CLK); @(posedge CLK); #1;
        tick();
        idle_inputs();
        tick();
        check("rst_ready", 32'(s_ready), 32'd1);

        // Test 1: sym2 = '110' -> 1,1,0 with last on the third bit.
        write_tbl(4'd0, 16'h0000, 5'd1);
        write_tbl(4'd1, 16'h0002, 5'd2);
        write_tbl(4'd2, 16'h0006, 5'd3);
        send(4'd2);
        tick(); check("t1_b1", 32'({s_valid, s_out, s_last}), 32'b110);
        tick(); check("t1_b2", 32'({s_valid, s_out, s_last}), 32'b110);
        tick(); check("t1_b3", 32'({s_valid, s_out, s_last}), 32'b101);
        tick(); check("t1_idle", 32'(s_valid), 32'd0);

        // Tests 2/3: continuous valid with syms 1,0,1.
        begin
            logic [3:0] seq [3];
            int k;
            seq[0] = 4'd1; seq[1] = 4'd0; seq[2] = 4'd1;
            k = 0;
            for (int c = 0; c < 12; c++) begin
                idle_inputs();
                if (k < 3) begin
                    sym_in_valid = 1; sym_in = seq[k];
                    if (s_ready === 1'b1 || c == 0) begin end
                end
                begin
                    logic acc;
                    acc = sym_in_valid && !Reset && (m_q.size() == 0) && (!m_valid || (PF && m_last));
                    tick();
                    if (acc) k++;
                end
            end
            check("t2_all_sent", 32'(k), 32'd3);
        end

        // Test 4: 16-bit code 0xFFFE -> fifteen 1s then a 0.
        write_tbl(4'd15, 16'hFFFE, 5'd16);
        send(4'd15);
        ones = 0; lasts = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (s_valid && s_out) ones++;
            if (s_last) lasts++;
        end
        check("t4_ones", 32'(ones), 32'd15);
        check("t4_lasts", 32'(lasts), 32'd1);
        check("t4_lastbit", 32'({s_out, s_last}), 32'b01);

        // Length clamp: len 31 stored as 16.
        write_tbl(4'd9, 16'h8001, 5'd31);
        send(4'd9);
        for (int i = 0; i < 17; i++) tick();

        // Test 5: unassigned symbol.
        send(4'd7);
        tick(); check("t5_err", 32'({s_err, s_valid}), 32'b10);
        tick(); check("t5_err_once", 32'({s_err, s_ready}), 32'b01);

        // Test 6: reset during bit 2 of sym2, then sym2 errors.
        send(4'd2);
        tick();
        Reset = 1; tick(); idle_inputs();
        tick(); check("t6_valid", 32'(s_valid), 32'd0);
        send(4'd2);
        tick(); check("t6_err", 32'(s_err), 32'd1);

        // Randomised traffic with table rewrites and occasional resets.
        for (int i = 0; i < 16; i++)
            write_tbl(4'(i), 16'($urandom), 5'($urandom_range(1, 16)));
        for (int c = 0; c < 4000; c++) begin
            idle_inputs();
            Reset        = ($urandom_range(0, 299) == 0);
            sym_in_valid = ($urandom_range(0, 3) != 0);
            sym_in       = 4'($urandom);
            tbl_wr_en    = ($urandom_range(0, 5) == 0);
            tbl_wr_sym   = 4'($urandom);
            tbl_wr_code  = 16'($urandom);
            tbl_wr_len   = 5'($urandom_range(0, 20));
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 20; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
